// File: rtl/excess3_to_bcd_seq.sv
// Excess-3 to packed-BCD converter, one digit per clock, LSD first.
// Word accepted over valid/ready, result held on a registered valid/ready
// output until the downstream takes it.

// Single-digit decode: Excess-3 code to BCD digit plus invalid-code flag.
module excess3_digit_dec (
    input  logic [3:0] code_i,
    output logic [3:0] bcd_o,
    output logic       err_o
);
    // Codes 3..C are legal; anything else decodes to 0 with the flag set.
    always_comb begin
        err_o = (code_i < 4'h3) || (code_i > 4'hC);
        bcd_o = err_o ? 4'h0 : (code_i - 4'h3);
    end
endmodule

module excess3_to_bcd_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  out_err
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  cap_q, cap_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [DIGITS-1:0]    mask_q, mask_d;
    logic                 err_q, err_d;

    logic [3:0]           cur_code;
    logic [3:0]           dig_bcd;
    logic                 dig_err;

    // Digit under conversion comes from the captured copy, never from in_data.
    assign cur_code = cap_q[4*int'(cnt_q) +: 4];

    excess3_digit_dec u_dec (
        .code_i (cur_code),
        .bcd_o  (dig_bcd),
        .err_o  (dig_err)
    );

    // Handshake flags are pure state decode; result ports are registers.
    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_bcd      = bcd_q;
    assign out_err_mask = mask_q;
    assign out_err      = err_q;

    // Next-state and datapath update; everything holds unless the state acts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        bcd_d   = bcd_q;
        mask_d  = mask_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cap_d   = in_data;
                    bcd_d   = '0;
                    mask_d  = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d[4*int'(cnt_q) +: 4] = dig_bcd;
                mask_d[cnt_q]             = dig_err;
                // Error summary updates in the same edge as the mask bit.
                err_d = |mask_d;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            bcd_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            bcd_q   <= bcd_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/excess3_to_bcd_seq.md
Name: excess3_to_bcd_seq

Overview:
- Multi-digit Excess-3 to packed-BCD converter; the return path for digits produced by the BCD-to-Excess-3 encode side.
- Accepts one packed Excess-3 word over a valid/ready handshake and converts one digit per clock, least-significant digit first.
- Flags non-Excess-3 codes per digit.
- Presents the packed BCD result on a registered valid/ready output held under backpressure.

Parameters:
DIGITS  4  number of 4-bit digits per word (>=1); data width = 4*DIGITS

Ports:
clk           in   1          system clock, rising edge
rst_n         in   1          asynchronous active-low reset
in_valid      in   1          in_data valid
in_ready      out  1          block can accept a word
in_data       in   4*DIGITS   packed Excess-3 word; digit k = bits [4k+3:4k]
out_valid     out  1          result valid
out_ready     in   1          downstream accepts result
out_bcd       out  4*DIGITS   packed BCD result, same digit ordering
out_err_mask  out  DIGITS     bit k set = input digit k was an invalid Excess-3 code
out_err       out  1          OR of out_err_mask

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; digit counter=0; capture reg, out_bcd and out_err_mask all 0.
  - out_valid=0, out_err=0; in_ready=1, because it decodes state==IDLE.
- All outputs come from registers or state decode; there is no combinational in->out path.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at an edge:
    - Capture in_data.
    - Clear out_bcd and out_err_mask.
    - Set cnt=0 and go to CONV.
- CONV:
  - in_ready=0, out_valid=0.
  - Each edge converts capture digit cnt:
    - Valid code x in 4'h3..4'hC: out_bcd digit cnt = x-3 (4-bit subtract, no borrow possible), mask bit cnt = 0.
    - Invalid code (0,1,2,D,E,F): out_bcd digit cnt = 4'h0, mask bit cnt = 1.
  - cnt increments; cnt width = clog2(DIGITS), minimum 1 bit.
  - On the edge converting digit DIGITS-1, go to DONE and set cnt=0 (no wrap beyond DIGITS-1).
- DONE:
  - out_valid=1; out_bcd, out_err_mask and out_err are stable.
  - On out_valid&out_ready, go to IDLE.
  - While out_ready=0, hold all outputs indefinitely; in_valid is ignored.
- Latency: handshake at edge E0 → out_valid high after edge E_DIGITS, i.e. visible DIGITS cycles after acceptance.
- Throughput: one word per DIGITS+2 cycles with out_ready tied high.
- in_data changes while not in IDLE have no effect (captured copy is used).
- DIGITS=1: CONV lasts exactly one edge.
- out_err is registered alongside the mask and never lags it.
- Reset asserted mid-CONV or in DONE:
  - Immediate return to reset values; the partial result is discarded.
  - No out_valid pulse is produced for the aborted word.
- in_valid during reset is ignored; the first acceptance is at the first edge after rst_n releases.

Test Plan:
All with DIGITS=4.
1. in_data=16'h4567, out_ready=1 → 4 cycles after accept: out_valid=1, out_bcd=16'h1234, out_err_mask=4'b0000, out_err=0; in_ready back to 1 the cycle after the output handshake.
2. Boundaries:
   - in_data=16'h3333 → out_bcd=16'h0000, err=0.
   - Next word 16'hCCCC → out_bcd=16'h9999, err=0.
   - Back-to-back accepts are spaced exactly 6 cycles apart.
3. in_data=16'h45F7 → out_bcd=16'h1204, out_err_mask=4'b0010, out_err=1. Then in_data=16'h0D21 → out_bcd=16'h0000, mask=4'b1111.
4. Backpressure:
   - Accept 16'h9876 with out_ready=0 for 5 cycles after out_valid rises → out_bcd=16'h6543 held constant, out_valid stays 1.
   - in_ready=0 throughout; a toggling in_valid/in_data is not captured.
   - Releasing out_ready → single handshake, then IDLE.
5. Reset: accept 16'h5555, pull rst_n low after 2 CONV edges → asynchronously out_valid=0, out_bcd=0, in_ready=1. After release, accepting 16'h3456 → out_bcd=16'h0123 with no residue from the aborted word.
